// File: rtl/sad_window_min_tracker.sv
// Accumulates two lanes of partial SADs into 4x4 window sums and tracks the minimum and its candidate index.
// Optional build macro SAD_EARLY_EXIT_EN: end the search as soon as the running minimum reaches zero.
module sad_window_min_tracker #(
    parameter int BEATS_PER_WINDOW = 4,
    parameter int NUM_PAIRS        = 64,
    parameter int SUM_W            = 16,
    parameter int IDX_W            = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [12:0]      SAD_value_small_A,
    input  logic [12:0]      SAD_value_small_B,
    input  logic             InValid,
    output logic             InReady,
    output logic             Busy,
    output logic             Done,
    output logic [SUM_W-1:0] MinSAD,
    output logic [IDX_W-1:0] MinIndex
);

    localparam int DATA_W = 13;
    localparam int BC_W   = (BEATS_PER_WINDOW > 1) ? $clog2(BEATS_PER_WINDOW) : 1;
    localparam int PC_W   = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS_PER_WINDOW - 1);
    localparam logic [PC_W-1:0] LAST_PAIR = PC_W'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [BC_W-1:0]   beat_cnt;
    logic [PC_W-1:0]   pair_cnt;
    logic [SUM_W-1:0]  acc_a, acc_b;

    logic              xfer;
    logic              last_beat;
    logic              win_b;
    logic [SUM_W-1:0]  win_sad;
    logic              upd;
    logic [SUM_W-1:0]  min_upd;
    logic [IDX_W-1:0]  win_idx;
    logic              finish;

    function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] v);
        return SUM_W'(v);
    endfunction

    // Pair comparison: lane A wins ties, and only a strictly smaller sum displaces the running minimum
    always_comb begin
        xfer      = (state == S_ACCUM) && InValid;
        last_beat = (beat_cnt == LAST_BEAT);
        win_b     = (acc_b < acc_a);
        win_sad   = win_b ? acc_b : acc_a;
        upd       = (win_sad < MinSAD);
        min_upd   = upd ? win_sad : MinSAD;
        win_idx   = '0;
        win_idx[PC_W:0] = {pair_cnt, win_b};
        finish    = (pair_cnt == LAST_PAIR);
`ifdef SAD_EARLY_EXIT_EN
        if (min_upd == '0) begin
            finish = 1'b1;
        end
`else
`endif
    end

    always_comb begin
        state_nxt = state;
        InReady   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (xfer && last_beat) begin
                    state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                Busy      = 1'b1;
                state_nxt = finish ? S_DONE : S_ACCUM;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            beat_cnt <= '0;
            pair_cnt <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            MinSAD   <= '1;
            MinIndex <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        beat_cnt <= '0;
                        pair_cnt <= '0;
                        acc_a    <= '0;
                        acc_b    <= '0;
                        MinSAD   <= '1;
                        MinIndex <= '0;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc_a    <= acc_a + zext(SAD_value_small_A);
                        acc_b    <= acc_b + zext(SAD_value_small_B);
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (upd) begin
                        MinSAD   <= win_sad;
                        MinIndex <= win_idx;
                    end
                    acc_a <= '0;
                    acc_b <= '0;
                    if (!finish) begin
                        pair_cnt <= pair_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_window_min_tracker.sv
// Directed bench for sad_window_min_tracker with a 4-pair search; covers reset, ties, stalls, max values, early exit.
module tb_sad_window_min_tracker;

    localparam int NP = 4;

    logic        Clk = 1'b0;
    logic        Reset, Start, InValid;
    logic [12:0] SAD_value_small_A, SAD_value_small_B;
    logic        InReady, Busy, Done;
    logic [15:0] MinSAD;
    logic [7:0]  MinIndex;

    int n_cmp = 0;
    int n_err = 0;

    logic [12:0] pa [NP];
    logic [12:0] pb [NP];

    sad_window_min_tracker #(
        .BEATS_PER_WINDOW(4),
        .NUM_PAIRS(NP),
        .SUM_W(16),
        .IDX_W(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .SAD_value_small_A(SAD_value_small_A),
        .SAD_value_small_B(SAD_value_small_B),
        .InValid(InValid),
        .InReady(InReady),
        .Busy(Busy),
        .Done(Done),
        .MinSAD(MinSAD),
        .MinIndex(MinIndex)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic send_beat(input logic [12:0] a, input logic [12:0] b);
        int n;
        n = 0;
        SAD_value_small_A = a;
        SAD_value_small_B = b;
        InValid = 1'b1;
        while (!InReady && n < 20) begin
            step();
            n++;
        end
        check("beat_ready", {31'd0, InReady}, 32'd1);
        step();
        InValid = 1'b0;
    endtask

    task automatic run_search(input bit gaps, input bit poke_start);
        pulse_start();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (gaps && (k % 2 == 1)) begin
                    step();
                    step();
                end
                if (poke_start && p == 1 && k == 1) Start = 1'b1;
                send_beat(pa[p], pb[p]);
                Start = 1'b0;
                if (p == 0 && k == 3) begin
                    check("compare_inready", {31'd0, InReady}, 32'd0);
                end
            end
        end
        check("done_early", {31'd0, Done}, 32'd0);
        check("compare_busy", {31'd0, Busy}, 32'd1);
        step();
        check("done_pulse", {31'd0, Done}, 32'd1);
        check("done_busy", {31'd0, Busy}, 32'd0);
        step();
        check("done_clear", {31'd0, Done}, 32'd0);
    endtask

    task automatic fill(input logic [12:0] a0, b0, a1, b1, a2, b2, a3, b3);
        pa[0] = a0; pb[0] = b0;
        pa[1] = a1; pb[1] = b1;
        pa[2] = a2; pb[2] = b2;
        pa[3] = a3; pb[3] = b3;
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        InValid = 1'b0;
        SAD_value_small_A = '0;
        SAD_value_small_B = '0;
        step();
        step();
        Reset = 1'b0;
        check("rst_inready", {31'd0, InReady}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_minsad", {16'd0, MinSAD}, 32'hFFFF);
        check("rst_minidx", {24'd0, MinIndex}, 32'd0);

        // Reset mid-ACCUM discards partial sums
        pulse_start();
        check("accum_busy", {31'd0, Busy}, 32'd1);
        check("accum_inready", {31'd0, InReady}, 32'd1);
        send_beat(13'd100, 13'd200);
        send_beat(13'd100, 13'd200);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_inready", {31'd0, InReady}, 32'd0);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_minsad", {16'd0, MinSAD}, 32'hFFFF);
        check("midrst_minidx", {24'd0, MinIndex}, 32'd0);
        fill(1, 1, 1, 1, 1, 1, 1, 1);
        run_search(1'b0, 1'b0);
        check("ones_minsad", {16'd0, MinSAD}, 32'd4);
        check("ones_minidx", {24'd0, MinIndex}, 32'd0);

        // Start coinciding with Reset is dropped
        Reset = 1'b1;
        Start = 1'b1;
        step();
        Reset = 1'b0;
        Start = 1'b0;
        check("start_rst_busy", {31'd0, Busy}, 32'd0);
        check("start_rst_minsad", {16'd0, MinSAD}, 32'hFFFF);

        // Main pattern: sums 200/240, 160/180, 160/120, 160/120
        fill(50, 60, 40, 45, 40, 30, 40, 30);
        run_search(1'b0, 1'b0);
        check("main_minsad", {16'd0, MinSAD}, 32'd120);
        check("main_minidx", {24'd0, MinIndex}, 32'd5);
        step();
        check("idle_hold_minsad", {16'd0, MinSAD}, 32'd120);
        check("idle_hold_minidx", {24'd0, MinIndex}, 32'd5);
        check("idle_inready", {31'd0, InReady}, 32'd0);

        // Tie inside every pair
        fill(7, 7, 7, 7, 7, 7, 7, 7);
        run_search(1'b0, 1'b0);
        check("tie_minsad", {16'd0, MinSAD}, 32'd28);
        check("tie_minidx", {24'd0, MinIndex}, 32'd0);

        // Stalled input gives the same result as the main pattern
        fill(50, 60, 40, 45, 40, 30, 40, 30);
        run_search(1'b1, 1'b0);
        check("stall_minsad", {16'd0, MinSAD}, 32'd120);
        check("stall_minidx", {24'd0, MinIndex}, 32'd5);

        // Max beat values with a stray Start mid-search
        fill(4092, 4092, 4092, 4092, 4092, 4092, 4092, 4092);
        run_search(1'b0, 1'b1);
        check("max_minsad", {16'd0, MinSAD}, 32'd16368);
        check("max_minidx", {24'd0, MinIndex}, 32'd0);

        // Zero-SAD pair: early exit only when the macro is defined
        pulse_start();
        for (int k = 0; k < 4; k++) send_beat(13'd5, 13'd6);
        for (int k = 0; k < 4; k++) send_beat(13'd0, 13'd0);
        step();
`ifdef SAD_EARLY_EXIT_EN
        check("exit_done", {31'd0, Done}, 32'd1);
        check("exit_minsad", {16'd0, MinSAD}, 32'd0);
        check("exit_minidx", {24'd0, MinIndex}, 32'd2);
        step();
        check("exit_idle_inready", {31'd0, InReady}, 32'd0);
        check("exit_idle_busy", {31'd0, Busy}, 32'd0);
`else
        check("noexit_done", {31'd0, Done}, 32'd0);
        check("noexit_inready", {31'd0, InReady}, 32'd1);
        for (int k = 0; k < 8; k++) send_beat(13'd3, 13'd3);
        step();
        check("noexit_done_end", {31'd0, Done}, 32'd1);
        check("noexit_minsad", {16'd0, MinSAD}, 32'd0);
        check("noexit_minidx", {24'd0, MinIndex}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sad_window_min_tracker.md
Name: sad_window_min_tracker

Overview:
- Consumer of the small-SAD adder outputs. Each beat delivers two 13-bit partial SADs: lane A and lane B, each a sum of four 10-bit absolute differences.
- Accumulates BEATS_PER_WINDOW beats per lane into full-window SADs, one for each of two adjacent candidate positions.
- Compares both window sums against a running minimum and tracks the winning candidate index.
- Feeds the best-match result back to the SAD instruction path of the processor core.

Parameters:
- BEATS_PER_WINDOW, 4, partial-sum beats per candidate window (4 beats x 4 pixels = 4x4 window).
- NUM_PAIRS, 64, candidate pairs per search; candidates = 2*NUM_PAIRS.
- SUM_W, 16, window-sum / min register width; must be >= 13 + clog2(BEATS_PER_WINDOW).
- IDX_W, 8, candidate index width; must be >= clog2(2*NUM_PAIRS).

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse begins a search; honoured only in IDLE.
- SAD_value_small_A  input  13  lane A partial sum.
- SAD_value_small_B  input  13  lane B partial sum.
- InValid  input  1  partial sums valid this cycle.
- InReady  output  1  block accepts a beat this cycle; a beat transfers when InValid && InReady.
- Busy  output  1  high in ACCUM/COMPARE.
- Done  output  1  one-cycle pulse when results are final.
- MinSAD  output  SUM_W  smallest window SAD found.
- MinIndex  output  IDX_W  index of that candidate (lane A of pair p = 2p, lane B = 2p+1).

Behaviour:
- Clocking and reset: one clock (Clk); Reset is synchronous and active-high.
- Reset values: state=IDLE, InReady=0, Busy=0, Done=0, MinSAD=all-ones, MinIndex=0. Beat counter, pair counter and both accumulators = 0.
- Mid-operation reset: Reset asserted in any state returns to IDLE with the reset values on the next edge. Partial results are discarded.
- IDLE:
  - InReady=0.
  - Start=1 -> ACCUM. Same edge: accumulators, counters cleared; MinSAD=all-ones; MinIndex=0.
  - MinSAD/MinIndex otherwise hold the last search result.
- ACCUM:
  - InReady=1, Busy=1.
  - On a transfer: accA += zero-extended SAD_value_small_A; accB += zero-extended SAD_value_small_B; beat counter increments.
  - If the transfer is beat BEATS_PER_WINDOW-1 -> COMPARE, beat counter wraps to 0.
  - InValid=0 stalls with no state change.
- COMPARE (exactly one cycle, InReady=0):
  - Pair winner: A if accA <= accB, else B.
  - Running minimum updates only if winner < MinSAD (strict), so on ties the earlier (lower) index wins.
  - MinIndex = 2*pair_cnt + (winner==B).
  - Accumulators cleared.
  - If pair_cnt == NUM_PAIRS-1 -> DONE; else pair_cnt+1 and -> ACCUM.
- DONE (one cycle): Done=1, Busy=0, InReady=0; -> IDLE.
- Latency: Done asserts 2 cycles after the final accepted beat.
- Arithmetic: unsigned throughout; no saturation needed given the SUM_W constraint. Comparison uses the full SUM_W.
- Start while not in IDLE is ignored. Start in the same cycle as Reset: Reset wins.
- InValid while InReady=0: beat not consumed; upstream must hold it.

Optional Feature:
- Macro SAD_EARLY_EXIT_EN.
- Defined: in COMPARE, if the updated MinSAD == 0, go directly to DONE regardless of pair_cnt. No further beats are accepted.
- Undefined: all NUM_PAIRS pairs are always processed.

Test Plan:
- Reset mid-ACCUM after 2 beats of A=100/B=200 -> next cycle IDLE, MinSAD=0xFFFF, MinIndex=0, InReady=0. Then Start, 4 beats of A=1/B=1 (NUM_PAIRS=1) -> MinSAD=4, MinIndex=0; no leftover sum from before the reset.
- NUM_PAIRS=4, BEATS=4, per-pair beats A/B = (50,60),(40,45),(40,30),(40,30) -> window sums 200/240, 160/180, 160/120, 160/120. Done 2 cycles after the 16th beat; MinSAD=120, MinIndex=5 (tie with index 7 keeps 5).
- Tie within a pair: all beats A=B=7 -> MinSAD=28, MinIndex=0.
- Stall: InValid toggled 1,0,0,1,... -> same result as unstalled; InReady=0 during COMPARE with InValid=1 -> that beat is held and accepted the next cycle.
- Max values: all beats A=B=4092 -> MinSAD=16368, no overflow. Start pulsed during Busy -> ignored, result unchanged.
- SAD_EARLY_EXIT_EN defined, NUM_PAIRS=64, pair 2 all-zero -> Done after pair 2's COMPARE, MinSAD=0, MinIndex=4. With the macro undefined -> Done only after pair 63.
